particle_incoming_collector: RTL and testbench

//  Receive side of a bin's motion-update router: accepts migrating particles from NUM_NEIGHBOR_BIN

---
 rtl/particle_incoming_collector.sv | 175 +++++++++++++++++
 tb/tb_particle_incoming_collector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/particle_incoming_collector.sv
// particle_incoming_collector
// Receive side of a bin's motion-update router. Neighbour lanes deliver at most
// one beat each per burst into per-lane hold registers; occupied holds are
// drained round-robin, one per cycle, into the bin particle RAM. The collector
// owns the bin particle count / write pointer and tells neighbours when a new
// burst may be offered.
// Optional feature: define PARTICLE_COLLECTOR_DROP_CNT_EN to count beats that
// were offered while the collector was not accepting (saturating 16-bit count).
module particle_incoming_collector #(
  parameter int NUM_NEIGHBOR_BIN        = 6,
  parameter int NEIGHBOR_BIN_ADDR_WIDTH = 3,
  parameter int DATA_WIDTH              = 160,
  parameter int ADDR_WIDTH              = 7,
  parameter int BIN_DEPTH               = 128
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   motion_update_enable,
  input  logic                                   local_count_clear,
  input  logic [NUM_NEIGHBOR_BIN-1:0]            global_incom_particle_data_valid,
  input  logic [NUM_NEIGHBOR_BIN*DATA_WIDTH-1:0] global_incom_particle_data_in,
  output logic                                   particle_input_available_to_neighbors,
  output logic                                   bin_wr_en,
  output logic [ADDR_WIDTH-1:0]                  bin_wr_addr,
  output logic [DATA_WIDTH-1:0]                  bin_wr_data,
  output logic [ADDR_WIDTH:0]                    local_particle_count,
  output logic                                   bin_full,
  output logic                                   collector_idle,
  output logic [15:0]                            drop_count
);

  localparam int LW = NEIGHBOR_BIN_ADDR_WIDTH;
  // A new burst is only invited if a full burst (one beat per lane) still fits.
  localparam logic [ADDR_WIDTH:0] CAP_LIMIT = (ADDR_WIDTH+1)'(BIN_DEPTH - NUM_NEIGHBOR_BIN);
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(BIN_DEPTH);
  localparam logic [LW:0]         NUM_C     = (LW+1)'(NUM_NEIGHBOR_BIN);
  localparam logic [LW-1:0]       LAST_LANE = LW'(NUM_NEIGHBOR_BIN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Hold stage: one beat per lane, valid travels with the data.
  logic [NUM_NEIGHBOR_BIN-1:0] hold_vld_p0;
  logic [DATA_WIDTH-1:0]       hold_data_p0 [NUM_NEIGHBOR_BIN];

  logic [ADDR_WIDTH:0]         count_q;
  logic [LW-1:0]               rr_ptr_q;

  logic [NUM_NEIGHBOR_BIN-1:0] accept;
  logic [NUM_NEIGHBOR_BIN-1:0] grant_mask;
  logic [NUM_NEIGHBOR_BIN-1:0] hold_vld_next;
  logic                        grant_found;
  logic [LW-1:0]               grant_idx;
  logic [LW-1:0]               rr_ptr_next;
  logic [ADDR_WIDTH:0]         count_base;
  logic [ADDR_WIDTH:0]         count_next;
  logic                        avail_next;

  // Round-robin arbiter: first occupied hold at or after rr_ptr, wrapping.
  always_comb begin
    logic [LW:0] lane_sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    lane_sum    = '0;
    for (int k = 0; k < NUM_NEIGHBOR_BIN; k++) begin
      lane_sum = {1'b0, rr_ptr_q} + (LW+1)'(k);
      if (lane_sum >= NUM_C) lane_sum = lane_sum - NUM_C;
      if (!grant_found && hold_vld_p0[lane_sum[LW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = lane_sum[LW-1:0];
      end
    end
  end

  // Next-state of holds, pointer, count and the neighbour-facing availability.
  always_comb begin
    accept      = global_incom_particle_data_valid &
                  {NUM_NEIGHBOR_BIN{particle_input_available_to_neighbors}};
    grant_mask  = '0;
    if (grant_found) grant_mask[grant_idx] = 1'b1;
    hold_vld_next = (hold_vld_p0 & ~grant_mask) | accept;
    rr_ptr_next = rr_ptr_q;
    if (grant_found) rr_ptr_next = (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
    // A clear coinciding with a drain write makes that write land at address 0.
    count_base  = local_count_clear ? '0 : count_q;
    count_next  = count_base + {{ADDR_WIDTH{1'b0}}, grant_found};
    // Availability drops for at least one cycle after any acceptance, so only
    // one burst is ever in flight and a lane hold is never overwritten.
    avail_next  = motion_update_enable && (hold_vld_next == '0) &&
                  (accept == '0) && (count_next <= CAP_LIMIT);
  end

  // Collector state: IDLE with all holds empty, DRAIN while any hold occupied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept != '0) state_d = DRAIN;
      DRAIN:   if (hold_vld_next == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: hold valids, count, pointer, availability, write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                               <= IDLE;
      hold_vld_p0                           <= '0;
      count_q                               <= '0;
      rr_ptr_q                              <= '0;
      particle_input_available_to_neighbors <= 1'b0;
      bin_wr_en                             <= 1'b0;
      bin_wr_addr                           <= '0;
    end else begin
      state_q                               <= state_d;
      hold_vld_p0                           <= hold_vld_next;
      count_q                               <= count_next;
      rr_ptr_q                              <= rr_ptr_next;
      particle_input_available_to_neighbors <= avail_next;
      bin_wr_en                             <= grant_found;
      if (grant_found) bin_wr_addr <= count_base[ADDR_WIDTH-1:0];
    end
  end

  // Data registers: capture accepted beats, forward the granted beat to the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEIGHBOR_BIN; i++) hold_data_p0[i] <= '0;
      bin_wr_data <= '0;
    end else begin
      for (int i = 0; i < NUM_NEIGHBOR_BIN; i++) begin
        if (accept[i]) hold_data_p0[i] <= global_incom_particle_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (grant_found) bin_wr_data <= hold_data_p0[grant_idx];
    end
  end

  assign local_particle_count = count_q;
  assign bin_full             = (count_q == DEPTH_C);
  assign collector_idle       = (state_q == IDLE);

`ifdef PARTICLE_COLLECTOR_DROP_CNT_EN
  function automatic logic [15:0] lane_popcount(input logic [NUM_NEIGHBOR_BIN-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < NUM_NEIGHBOR_BIN; i++) n = n + {15'b0, v[i]};
    return n;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0] drop_q;

  // Count beats offered while the collector was not accepting; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (!particle_input_available_to_neighbors) begin
      drop_q <= sat_add16(drop_q, lane_popcount(global_incom_particle_data_valid));
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_particle_incoming_collector.sv
// Scoreboard bench for particle_incoming_collector: a cycle-level reference
// model predicts RAM writes (queued) and per-cycle status; a monitor pops the
// queue whenever the DUT strobes bin_wr_en.
module tb_particle_incoming_collector;
  localparam int N     = 6;
  localparam int DW    = 160;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            clr;
  logic [N-1:0]    valid;
  logic [N*DW-1:0] data_in;
  logic            avail;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [AW:0]     count;
  logic            full;
  logic            idle;
  logic [15:0]     drop;

  always #5 clk = ~clk;

  particle_incoming_collector dut (
    .clk                                   (clk),
    .rst_n                                 (rst_n),
    .motion_update_enable                  (en),
    .local_count_clear                     (clr),
    .global_incom_particle_data_valid      (valid),
    .global_incom_particle_data_in         (data_in),
    .particle_input_available_to_neighbors (avail),
    .bin_wr_en                             (wr_en),
    .bin_wr_addr                           (wr_addr),
    .bin_wr_data                           (wr_data),
    .local_particle_count                  (count),
    .bin_full                              (full),
    .collector_idle                        (idle),
    .drop_count                            (drop)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  bit            m_avail;
  bit            m_wr;
  bit            m_hv[N];
  logic [DW-1:0] m_hd[N];
  int            m_rr;
  int            m_count;
  int            m_drop;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_avail = 0;
    m_wr    = 0;
    m_rr    = 0;
    m_count = 0;
    m_drop  = 0;
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 0;
      m_hd[i] = '0;
    end
    exp_q.delete();
  endtask

  // One clock edge of the reference behaviour, using the inputs being driven.
  task automatic model_edge();
    logic [N-1:0] acc;
    int base;
    int g;
    bit any;
    acc = m_avail ? valid : '0;
    if (!m_avail) begin
      m_drop += $countones(valid);
      if (m_drop > 65535) m_drop = 65535;
    end
    base = clr ? 0 : m_count;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int l;
      l = (m_rr + k) % N;
      if (g < 0 && m_hv[l]) g = l;
    end
    m_wr = (g >= 0);
    if (g >= 0) begin
      wr_t e;
      e.addr = base;
      e.data = m_hd[g];
      exp_q.push_back(e);
      m_hv[g] = 0;
      m_rr    = (g + 1) % N;
      m_count = base + 1;
    end else begin
      m_count = base;
    end
    any = 0;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        m_hv[i] = 1;
        m_hd[i] = data_in[i*DW +: DW];
      end
      any |= m_hv[i];
    end
    m_avail = en && !any && (acc == '0) && (m_count + N <= DEPTH);
  endtask

  task automatic check_outputs();
    bit any;
    any = 0;
    for (int i = 0; i < N; i++) any |= m_hv[i];
    chk("available", DW'(avail), DW'(m_avail));
    chk("wr_en", DW'(wr_en), DW'(m_wr));
    chk("count", DW'(count), DW'(m_count));
    chk("idle", DW'(idle), DW'(!any));
    chk("bin_full", DW'(full), DW'(m_count == DEPTH));
`ifdef PARTICLE_COLLECTOR_DROP_CNT_EN
    chk("drop_count", DW'(drop), DW'(m_drop));
`else
    chk("drop_count", DW'(drop), DW'(0));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_data(input bit lane_id);
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d;
      if (lane_id) d = DW'(i);
      else d = {$urandom, $urandom, $urandom, $urandom, $urandom};
      data_in[i*DW +: DW] = d;
    end
  endtask

  task automatic burst(input logic [N-1:0] mask, input bit lane_id);
    int w;
    w = 0;
    valid = '0;
    while (!m_avail && w < 50) begin
      tick();
      w++;
    end
    if (!m_avail) begin
      errors++;
      checks++;
      $display("FAIL burst_wait timeout mask=%0h count=%0d", mask, count);
    end else begin
      set_data(lane_id);
      valid = mask;
      tick();
      valid = '0;
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_wr_en", DW'(wr_en), DW'(0));
    chk("rst_mid_idle", DW'(idle), DW'(1));
    chk("rst_mid_count", DW'(count), DW'(0));
    chk("rst_mid_avail", DW'(avail), DW'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every DUT write must match the oldest predicted write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL wr_unexpected actual addr=%0d required=no write", wr_addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", DW'(wr_addr), DW'(e.addr));
          chk("wr_data", wr_data, e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    valid   = '0;
    data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_avail", DW'(avail), DW'(0));
    chk("reset_wr_en", DW'(wr_en), DW'(0));
    chk("reset_count", DW'(count), DW'(0));
    chk("reset_idle", DW'(idle), DW'(1));
    chk("reset_full", DW'(full), DW'(0));
    chk("reset_drop", DW'(drop), DW'(0));
    chk("reset_wr_addr", DW'(wr_addr), DW'(0));
    chk("reset_wr_data", wr_data, DW'(0));
    rst_n = 1'b1;

    // Enable after reset: available rises after the first edge.
    en = 1'b1;
    tick();
    chk("t1_avail", DW'(avail), DW'(1));

    // Beats offered while not available are dropped.
    en = 1'b0;
    tick();
    set_data(1'b0);
    valid = 6'b000100;
    repeat (3) tick();
    valid = '0;
`ifdef PARTICLE_COLLECTOR_DROP_CNT_EN
    chk("t5_drop", DW'(drop), DW'(3));
`else
    chk("t5_drop", DW'(drop), DW'(0));
`endif
    en = 1'b1;
    repeat (2) tick();

    // Full burst with data equal to lane id.
    burst(6'h3F, 1'b1);
    repeat (8) tick();
    chk("t2_count", DW'(count), DW'(6));

    // Round-robin order around a non-zero pointer.
    burst(6'b000100, 1'b0);
    burst(6'b010010, 1'b0);
    burst(6'b000011, 1'b0);
    repeat (6) tick();

    // Clear coinciding with the first drain write.
    burst(6'b111000, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    chk("t6_count", DW'(count), DW'(3));

    // Capacity boundary at 122 / 123.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int b = 0; b < 20; b++) burst(6'h3F, 1'b0);
    burst(6'b000011, 1'b0);
    repeat (4) tick();
    chk("t4_count122", DW'(count), DW'(122));
    chk("t4_avail122", DW'(avail), DW'(1));
    burst(6'b100000, 1'b0);
    repeat (4) tick();
    chk("t4_count123", DW'(count), DW'(123));
    chk("t4_avail123", DW'(avail), DW'(0));

    // Randomized traffic with occasional clears and disabled cycles.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 39) == 0);
      set_data(1'b0);
      if (m_avail) valid = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      else valid = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      tick();
    end
    valid = '0;
    clr   = 1'b0;
    en    = 1'b1;
    repeat (8) tick();

    // Asynchronous reset in the middle of a drain.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    burst(6'h3F, 1'b0);
    repeat (2) tick();
    reset_mid();
    en = 1'b1;
    repeat (10) tick();
    chk("final_queue_empty", DW'(exp_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
